// File: rtl/sync_fn_arbiter_pkg.sv
// Shared definitions for the function-unit arbiter: data width and tag sizing helper.
package sync_fn_arbiter_pkg;

    localparam int INT_N = 16;

    typedef logic [INT_N-1:0] int_t;

    // Tag/pointer width that stays at least one bit for degenerate sizes.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fn_arbiter_chk.sv
// Protocol watchdog for the shared unit's return channel.
module sync_fn_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic fn_out_valid,
    input logic fifo_empty
);

    // With no tag outstanding, the unit has no business presenting a result.
    unexpected_result_a: assert property (@(posedge clk) disable iff (rst) !(fn_out_valid && fifo_empty));

endmodule

// File: rtl/tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each result still inside the unit.
module tag_fifo
    import sync_fn_arbiter_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = tag_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] rd_r;
    logic [PW-1:0] wr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // No bypass: a full FIFO refuses a push even when a pop frees a slot this cycle.
    always_comb begin
        full      = (count_r == CW'(DEPTH));
        empty     = (count_r == {CW{1'b0}});
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
        head      = mem_r[rd_r];
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_r    <= {PW{1'b0}};
            wr_r    <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            rd_r <= do_pop_s  ? ptr_inc(rd_r) : rd_r;
            wr_r <= do_push_s ? ptr_inc(wr_r) : wr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag storage.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_r] <= din;
        end
    end

endmodule

// File: rtl/sync_fn_arbiter.sv
// Round-robin sharing of one valid/ready function unit among N requesters, with
// in-order result routing driven by a tag FIFO; zero added latency both ways.
module sync_fn_arbiter
    import sync_fn_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*INT_N-1:0]   req_data,
    output logic [N-1:0]         resp_valid,
    input  logic [N-1:0]         resp_ready,
    output logic [INT_N-1:0]     resp_data,
    output logic                 fn_in_valid,
    input  logic                 fn_in_ready,
    output logic [INT_N-1:0]     fn_in0,
    input  logic                 fn_out_valid,
    output logic                 fn_out_ready,
    input  logic [INT_N-1:0]     fn_out0
);

    localparam int TW = tag_width(N);

    logic [TW-1:0] rr_ptr_r;
    logic [TW-1:0] grant_s;
    logic [TW-1:0] head_s;
    logic          can_issue_s;
    logic          issue_s;
    logic          pop_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;

    function automatic logic [N-1:0] onehot(input logic [TW-1:0] idx);
        logic [N-1:0] v;
        v      = {N{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
    function automatic logic [TW-1:0] rr_pick(input logic [N-1:0] valid, input logic [TW-1:0] ptr);
        logic [2*N-1:0] dbl;
        logic [TW-1:0]  pick;
        logic [TW:0]    sum;
        dbl  = {valid, valid} >> ptr;
        pick = {TW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            pick = dbl[i] ? TW'(i) : pick;
        end
        sum = {1'b0, pick} + {1'b0, ptr};
        sum = (sum >= (TW+1)'(N)) ? sum - (TW+1)'(N) : sum;
        return sum[TW-1:0];
    endfunction

    // Issue path toward the unit.
    always_comb begin
        grant_s     = rr_pick(req_valid, rr_ptr_r);
        can_issue_s = (|req_valid) & ~fifo_full_s & ~rst;
        issue_s     = can_issue_s & fn_in_ready;
        fn_in_valid = can_issue_s;
        fn_in0      = req_data[32'(grant_s) * INT_N +: INT_N];
        if (issue_s) begin
            req_ready = onehot(grant_s);
        end else begin
            req_ready = {N{1'b0}};
        end
    end

    // Return path: the oldest tag decides who sees the result and whose ready counts.
    always_comb begin
        if (!fifo_empty_s && !rst) begin
            fn_out_ready = resp_ready[head_s];
            resp_valid   = fn_out_valid ? onehot(head_s) : {N{1'b0}};
        end else begin
            fn_out_ready = 1'b0;
            resp_valid   = {N{1'b0}};
        end
        resp_data = fn_out0;
        pop_s     = fn_out_valid & fn_out_ready;
    end

    // Round-robin pointer moves just past the requester that was served.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= {TW{1'b0}};
        end else if (issue_s) begin
            rr_ptr_r <= (grant_s == TW'(N - 1)) ? {TW{1'b0}} : grant_s + TW'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    tag_fifo #(
        .W     (TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue_s),
        .pop   (pop_s),
        .din   (grant_s),
        .head  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    sync_fn_arbiter_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .fn_out_valid (fn_out_valid),
        .fifo_empty   (fifo_empty_s)
    );

endmodule

// File: tb/tb_sync_fn_arbiter.sv
// Bench for sync_fn_arbiter: behavioural factorial unit plus queue-based reference model.
module tb_sync_fn_arbiter;
    import sync_fn_arbiter_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       req_valid  = '0;
    logic [N-1:0]       req_ready;
    logic [N*INT_N-1:0] req_data   = '0;
    logic [N-1:0]       resp_valid;
    logic [N-1:0]       resp_ready = '0;
    logic [INT_N-1:0]   resp_data;
    logic               fn_in_valid;
    logic               fn_in_ready  = 1'b0;
    logic [INT_N-1:0]   fn_in0;
    logic               fn_out_valid = 1'b0;
    logic               fn_out_ready;
    logic [INT_N-1:0]   fn_out0      = '0;

    always #5 clk = ~clk;

    sync_fn_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .fn_in_valid  (fn_in_valid),
        .fn_in_ready  (fn_in_ready),
        .fn_in0       (fn_in0),
        .fn_out_valid (fn_out_valid),
        .fn_out_ready (fn_out_ready),
        .fn_out0      (fn_out0)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    // Requester operand rings, in-flight model (issue order) and shared-unit model.
    int ops [N][16];
    int op_head [N];
    int op_tail [N];
    int inflight_req[$];
    int inflight_val[$];
    int unit_val[$];
    int unit_due[$];
    int grant_log[$];
    int resp_req_log[$];
    int resp_dat_log[$];
    int ptr_m     = 0;
    int pushpop_n = 0;
    int lat_lo    = 0;
    int lat_hi    = 0;
    bit in_rand   = 1'b0;
    bit rst_v     = 1'b1;
    logic [N-1:0] rr_v = '1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int fact(input int n);
        int r = 1;
        for (int k = 2; k <= n; k++) r = r * k;
        return r & 32'hFFFF;
    endfunction

    function automatic bit busy();
        bit b = (inflight_req.size() > 0);
        for (int i = 0; i < N; i++) if (op_head[i] != op_tail[i]) b = 1'b1;
        return b;
    endfunction

    task automatic add_op(input int i, input int v);
        ops[i][op_tail[i] % 16] = v;
        op_tail[i]++;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        resp_req_log.delete();
        resp_dat_log.delete();
    endtask

    // One clock: drive at negedge, compare at negedge+1, advance models at posedge.
    task automatic cycle();
        int g, h, val;
        bit can, issue, pop;
        @(negedge clk);
        rst = rst_v;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (op_head[i] != op_tail[i]);
            req_data[i*INT_N +: INT_N] = req_valid[i] ? INT_N'(ops[i][op_head[i] % 16]) : INT_N'($urandom);
        end
        resp_ready   = rr_v;
        fn_in_ready  = in_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        fn_out_valid = (unit_val.size() > 0) && (unit_due[0] <= cyc);
        fn_out0      = fn_out_valid ? INT_N'(unit_val[0]) : INT_N'($urandom);
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        end
        can   = !rst_v && (g >= 0) && (inflight_req.size() < DEPTH);
        issue = can && fn_in_ready;
        h     = (inflight_req.size() > 0) ? inflight_req[0] : 0;
        pop   = !rst_v && (inflight_req.size() > 0) && fn_out_valid && rr_v[h];
        chk("fn_in_valid", 32'(fn_in_valid), 32'(can));
        chk("req_ready", 32'(req_ready), issue ? (1 << g) : 0);
        if (can) chk("fn_in0", 32'(fn_in0), ops[g][op_head[g] % 16]);
        chk("resp_valid", 32'(resp_valid),
            (!rst_v && inflight_req.size() > 0 && fn_out_valid) ? (1 << h) : 0);
        chk("fn_out_ready", 32'(fn_out_ready),
            32'(!rst_v && inflight_req.size() > 0 && rr_v[h]));
        if (pop) begin
            chk("resp_data", 32'(resp_data), inflight_val[0]);
            resp_req_log.push_back(h);
            resp_dat_log.push_back(32'(resp_data));
        end
        if (issue && pop && inflight_req.size() == DEPTH - 1) pushpop_n++;
        @(posedge clk);
        cyc++;
        if (rst_v) begin
            inflight_req.delete();
            inflight_val.delete();
            unit_val.delete();
            unit_due.delete();
            ptr_m = 0;
        end else begin
            if (pop) begin
                void'(inflight_req.pop_front());
                void'(inflight_val.pop_front());
                void'(unit_val.pop_front());
                void'(unit_due.pop_front());
            end
            if (issue) begin
                val = fact(ops[g][op_head[g] % 16]);
                inflight_req.push_back(g);
                inflight_val.push_back(val);
                unit_val.push_back(val);
                unit_due.push_back(cyc + int'($urandom_range(lat_lo, lat_hi)));
                op_head[g]++;
                ptr_m = (g + 1) % N;
                grant_log.push_back(g);
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_v = 1'b1;
        repeat (n) cycle();
        rst_v = 1'b0;
    endtask

    task automatic run_idle(input int maxc);
        int c = 0;
        while (busy() && c < maxc) begin
            cycle();
            c++;
        end
        if (busy()) chk("drain_timeout", 1, 0);
    endtask

    task automatic chk_logs(input string tag, input int n, input int reqs[8], input int dats[8], input bit use_grants);
        if (use_grants) begin
            chk({tag, "_ngrant"}, grant_log.size(), n);
            for (int i = 0; i < n && i < grant_log.size(); i++) chk({tag, "_grant"}, grant_log[i], reqs[i]);
        end else begin
            chk({tag, "_nresp"}, resp_req_log.size(), n);
            for (int i = 0; i < n && i < resp_req_log.size(); i++) begin
                chk({tag, "_resp_req"}, resp_req_log[i], reqs[i]);
                chk({tag, "_resp_data"}, resp_dat_log[i], dats[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            op_head[i] = 0;
            op_tail[i] = 0;
        end
        do_reset(2);

        // Single requester.
        clear_logs();
        add_op(1, 8);
        run_idle(50);
        chk_logs("single", 1, '{1, 0, 0, 0, 0, 0, 0, 0}, '{40320, 0, 0, 0, 0, 0, 0, 0}, 1'b0);

        // All four valid at once from ptr=0.
        do_reset(1);
        clear_logs();
        add_op(0, 5); add_op(1, 3); add_op(2, 0); add_op(3, 8);
        run_idle(50);
        chk_logs("all4", 4, '{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1);
        chk_logs("all4", 4, '{0, 1, 2, 3, 0, 0, 0, 0}, '{120, 6, 1, 40320, 0, 0, 0, 0}, 1'b0);

        // Fairness between two continuously valid requesters.
        do_reset(1);
        clear_logs();
        for (int k = 1; k <= 3; k++) begin
            add_op(0, k);
            add_op(2, k + 3);
        end
        run_idle(60);
        chk_logs("fair", 6, '{0, 2, 0, 2, 0, 2, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1);

        // Head-of-line backpressure fills the FIFO, then drains in order.
        do_reset(1);
        clear_logs();
        rr_v = 4'b1110;
        for (int k = 1; k <= 5; k++) add_op(0, k);
        repeat (12) cycle();
        chk("bp_issued", grant_log.size(), 4);
        rr_v = 4'b1111;
        run_idle(60);
        chk_logs("bp", 5, '{0, 0, 0, 0, 0, 0, 0, 0}, '{1, 2, 6, 24, 120, 0, 0, 0}, 1'b0);

        // Reset while two requests are in flight.
        do_reset(1);
        lat_lo = 5; lat_hi = 5;
        add_op(0, 4); add_op(1, 5);
        repeat (3) cycle();
        do_reset(1);
        clear_logs();
        lat_lo = 1; lat_hi = 1;
        add_op(3, 3);
        run_idle(50);
        chk_logs("rst_mid", 1, '{3, 0, 0, 0, 0, 0, 0, 0}, '{6, 0, 0, 0, 0, 0, 0, 0}, 1'b0);

        // Randomized traffic with a reset in the middle.
        lat_lo = 0; lat_hi = 6; in_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0 && (op_tail[i] - op_head[i]) < 3)
                    add_op(i, int'($urandom_range(0, 8)));
            end
            for (int i = 0; i < N; i++) rr_v[i] = ($urandom_range(0, 4) != 0);
            if (c == 1500) rst_v = 1'b1;
            cycle();
            rst_v = 1'b0;
        end
        rr_v = '1;
        run_idle(500);
        chk("pushpop_at_depth_m1_seen", 32'(pushpop_n > 0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
